// File: rtl/trace_step_emitter.sv
// trace_step_emitter: packs one trace step into the 560-bit step word and streams it MSB-first.
// Latency: first beat is valid 1 cycle after the step is accepted; back-to-back steps have no bubble.
// Backpressure: out_data/out_last hold while out_valid && !out_ready; in_ready is low while a step is held.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       step handshake; in_instr, in_e*x.. in_eflags, in_hint{1,2}_* are the components
//   out_valid / out_ready     beat handshake; out_data is BEAT_W bits, out_last marks the step's final beat
//   busy                      a step is held and not yet fully sent
//
// Optional feature: define TRACE_EMIT_CHECKSUM_EN to append one XOR-checksum beat after the data beats.
module trace_step_emitter #(
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [95:0]       in_instr,
  input  logic [31:0]       in_eax,
  input  logic [31:0]       in_ebx,
  input  logic [31:0]       in_ecx,
  input  logic [31:0]       in_edx,
  input  logic [31:0]       in_esi,
  input  logic [31:0]       in_edi,
  input  logic [31:0]       in_esp,
  input  logic [31:0]       in_ebp,
  input  logic [31:0]       in_eip,
  input  logic [31:0]       in_eflags,
  input  logic [1:0]        in_hint1_mask,
  input  logic [1:0]        in_hint2_mask,
  input  logic              in_hint1_rw,
  input  logic              in_hint2_rw,
  input  logic [31:0]       in_hint1_address,
  input  logic [31:0]       in_hint2_address,
  input  logic [31:0]       in_hint1_data,
  input  logic [31:0]       in_hint2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int NBEATS = 560 / BEAT_W;
  localparam int BIW    = $clog2(NBEATS + 1);

  // The step word must split into whole beats.
  if (BEAT_W < 1 || BEAT_W > 560 || (560 % BEAT_W) != 0) begin : g_bad_beat_w
    $error("trace_step_emitter: BEAT_W must divide 560");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef TRACE_EMIT_CHECKSUM_EN
  localparam logic [1:0] S_CSUM = 2'd2;
`endif

  logic [1:0]        state;
  logic [559:0]      sreg;       // unsent part of the step, next beat in the top BEAT_W bits
  logic [BIW-1:0]    beat_idx;
  logic [559:0]      step_word;
  logic [BEAT_W-1:0] head_beat;
  logic              last_data;
  logic              final_beat;
  logic              accept;

  assign step_word = {in_instr,
                      in_eax, in_ebx, in_ecx, in_edx, in_esi,
                      in_edi, in_esp, in_ebp, in_eip, in_eflags,
                      in_hint1_mask, in_hint1_rw, 5'b0, in_hint1_address, in_hint1_data,
                      in_hint2_mask, in_hint2_rw, 5'b0, in_hint2_address, in_hint2_data};

  assign head_beat = sreg[559 -: BEAT_W];
  assign last_data = (state == S_SEND) && (beat_idx == BIW'(NBEATS - 1));

`ifdef TRACE_EMIT_CHECKSUM_EN
  logic [BEAT_W-1:0] csum;

  assign final_beat = (state == S_CSUM);
  assign out_data   = final_beat ? csum : head_beat;
`else
  assign final_beat = last_data;
  assign out_data   = head_beat;
`endif

  assign out_valid = (state != S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_last  = final_beat;

  // Ready while idle, or in the step's final beat cycle when that beat is leaving,
  // so a following step can be loaded with no bubble.
  assign in_ready = !rst && ((state == S_IDLE) || (final_beat && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sreg     <= '0;
      beat_idx <= '0;
`ifdef TRACE_EMIT_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (accept) begin
      state    <= S_SEND;
      sreg     <= step_word;
      beat_idx <= '0;
`ifdef TRACE_EMIT_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (state == S_SEND && out_ready) begin
      sreg     <= sreg << BEAT_W;
      beat_idx <= beat_idx + BIW'(1);
`ifdef TRACE_EMIT_CHECKSUM_EN
      // Only handshaken beats are folded in, so stalls cannot disturb the sum.
      csum     <= csum ^ head_beat;
      if (last_data) state <= S_CSUM;
`else
      if (last_data) state <= S_IDLE;
`endif
    end
`ifdef TRACE_EMIT_CHECKSUM_EN
    else if (state == S_CSUM && out_ready) begin
      state <= S_IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_trace_step_emitter.sv
module tb_trace_step_emitter;

  localparam int NB = 70;
`ifdef TRACE_EMIT_CHECKSUM_EN
  localparam int NT = 71;
`else
  localparam int NT = 70;
`endif

  typedef struct packed {
    logic [95:0] instr;
    logic [31:0] eax, ebx, ecx, edx, esi, edi, esp, ebp, eip, eflags;
    logic [1:0]  h1m;
    logic        h1rw;
    logic [31:0] h1a, h1d;
    logic [1:0]  h2m;
    logic        h2rw;
    logic [31:0] h2a, h2d;
  } step_t;

  logic clk = 0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [95:0] in_instr;
  logic [31:0] in_eax, in_ebx, in_ecx, in_edx, in_esi, in_edi, in_esp, in_ebp, in_eip, in_eflags;
  logic [1:0]  in_hint1_mask, in_hint2_mask;
  logic        in_hint1_rw, in_hint2_rw;
  logic [31:0] in_hint1_address, in_hint2_address, in_hint1_data, in_hint2_data;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

  trace_step_emitter #(.BEAT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_eax(in_eax), .in_ebx(in_ebx), .in_ecx(in_ecx), .in_edx(in_edx),
    .in_esi(in_esi), .in_edi(in_edi), .in_esp(in_esp), .in_ebp(in_ebp), .in_eip(in_eip),
    .in_eflags(in_eflags), .in_hint1_mask(in_hint1_mask), .in_hint2_mask(in_hint2_mask),
    .in_hint1_rw(in_hint1_rw), .in_hint2_rw(in_hint2_rw),
    .in_hint1_address(in_hint1_address), .in_hint2_address(in_hint2_address),
    .in_hint1_data(in_hint1_data), .in_hint2_data(in_hint2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] beats[$];
  bit         lasts[$];

  function automatic logic [559:0] pack(input step_t s);
    return {s.instr, s.eax, s.ebx, s.ecx, s.edx, s.esi, s.edi, s.esp, s.ebp, s.eip, s.eflags,
            s.h1m, s.h1rw, 5'b0, s.h1a, s.h1d, s.h2m, s.h2rw, 5'b0, s.h2a, s.h2d};
  endfunction

  function automatic logic [559:0] word_at(input int base);
    logic [559:0] w = '0;
    for (int i = 0; i < NB; i++) w = {w[551:0], beats[base + i]};
    return w;
  endfunction

  function automatic int count_lasts();
    int n = 0;
    foreach (lasts[i]) if (lasts[i]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [559:0] obs, input logic [559:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input step_t s);
    in_instr = s.instr; in_eax = s.eax; in_ebx = s.ebx; in_ecx = s.ecx; in_edx = s.edx;
    in_esi = s.esi; in_edi = s.edi; in_esp = s.esp; in_ebp = s.ebp; in_eip = s.eip;
    in_eflags = s.eflags;
    in_hint1_mask = s.h1m; in_hint1_rw = s.h1rw; in_hint1_address = s.h1a; in_hint1_data = s.h1d;
    in_hint2_mask = s.h2m; in_hint2_rw = s.h2rw; in_hint2_address = s.h2a; in_hint2_data = s.h2d;
  endtask

  task automatic rand_step(output step_t s);
    logic [575:0] r;
    for (int i = 0; i < 18; i++) r[i*32 +: 32] = $urandom();
    s = step_t'(r[$bits(step_t)-1:0]);
  endtask

  // Called at posedge+1 with the emitter idle: present s for one edge, then scramble the inputs.
  task automatic accept(input string tag, input step_t s);
    step_t junk;
    drive(s);
    in_valid = 1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    rand_step(junk);
    drive(junk);
  endtask

  // Receive beats until the last handshake (or maxb beats), checking stall stability.
  task automatic collect(input int pct, input int maxb);
    int   cyc = 0;
    bit   stalled = 0;
    logic [7:0] hd = '0;
    logic hl = 0;
    beats.delete();
    lasts.delete();
    forever begin
      out_ready = ($urandom_range(99) < pct);
      #1;
      if (stalled) begin
        check("stall_data", out_data, hd);
        check("stall_last", out_last, hl);
      end
      stalled = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      if (out_valid && out_ready) begin
        beats.push_back(out_data);
        lasts.push_back(out_last);
      end
      @(posedge clk); #1;
      cyc++;
      if (beats.size() > 0 && (lasts[$] || beats.size() >= maxb)) break;
      if (cyc > 2000) begin
        check("collect_timeout", beats.size(), maxb);
        break;
      end
    end
    out_ready = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step_t s, a, b;
    int    cyc;
    bit    got_b;

    rst = 1; in_valid = 0; out_ready = 0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_low", in_ready, 0);
    rst = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic step: instr first byte 0x90, eax 0x11223344.
    s = '0;
    s.instr = {8'h90, 88'h0};
    s.eax   = 32'h11223344;
    out_ready = 1;
    accept("t1", s);
    #1;
    check("t1_latency_valid", out_valid, 1);
    check("t1_first_beat", out_data, 8'h90);
    check("t1_busy", busy, 1);
    check("t1_in_ready_send", in_ready, 0);
    collect(100, NT);
    check("t1_nbeats", beats.size(), NT);
    check("t1_beat0", beats[0], 8'h90);
    check("t1_beat12", beats[12], 8'h11);
    check("t1_beat13", beats[13], 8'h22);
    check("t1_beat15", beats[15], 8'h44);
    check("t1_last_count", count_lasts(), 1);
    check("t1_last_pos", lasts[NT-1], 1);
    check_word("t1_word", word_at(0), pack(s));
    #1;
    check("t1_idle_valid", out_valid, 0);
    check("t1_idle_busy", busy, 0);

    // First memory hint: header byte and address.
    s = '0;
    s.h1m  = 2'b11;
    s.h1rw = 1;
    s.h1a  = 32'hDEADBEEF;
    accept("t2", s);
    collect(100, NT);
    check("t2_beat51", beats[51], 8'h00);
    check("t2_beat52", beats[52], 8'hE0);
    check("t2_beat53", beats[53], 8'hDE);
    check("t2_beat54", beats[54], 8'hAD);
    check("t2_beat55", beats[55], 8'hBE);
    check("t2_beat56", beats[56], 8'hEF);

    // Random fields, random backpressure.
    rand_step(s);
    accept("t3", s);
    collect(50, NT);
    check("t3_nbeats", beats.size(), NT);
    check("t3_last_count", count_lasts(), 1);
    check_word("t3_word", word_at(0), pack(s));

    // Back-to-back steps with in_valid held high.
    rand_step(a);
    rand_step(b);
    drive(a);
    in_valid = 1;
    out_ready = 1;
    #1;
    check("t4_a_in_ready", in_ready, 1);
    @(posedge clk); #1;
    drive(b);
    beats.delete();
    lasts.delete();
    got_b = 0;
    cyc = 0;
    forever begin
      #1;
      if (!out_valid) break;
      beats.push_back(out_data);
      lasts.push_back(out_last);
      if (in_valid && in_ready) begin
        check("t4_accept_on_last", out_last, 1);
        check("t4_accept_pos", beats.size(), NT);
        got_b = 1;
      end
      @(posedge clk); #1;
      if (got_b) in_valid = 0;
      cyc++;
      if (cyc > 400) break;
    end
    in_valid = 0;
    check("t4_b_accepted", got_b, 1);
    check("t4_run_length", beats.size(), 2 * NT);
    check_word("t4_word_a", word_at(0), pack(a));
    check_word("t4_word_b", word_at(NT), pack(b));

    // Reset mid-step discards it.
    @(posedge clk); #1;
    rand_step(a);
    accept("t5a", a);
    collect(100, 31);
    check("t5_partial", beats.size(), 31);
    check("t5_partial_last", count_lasts(), 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_last", out_last, 0);
    rand_step(b);
    accept("t5b", b);
    collect(100, NT);
    check("t5_nbeats", beats.size(), NT);
    check_word("t5_word", word_at(0), pack(b));

`ifdef TRACE_EMIT_CHECKSUM_EN
    // Checksum beat: eax=0xFF only, so XOR of data beats is 0xFF.
    s = '0;
    s.eax = 32'h000000FF;
    accept("t6", s);
    collect(50, NT);
    check("t6_nbeats", beats.size(), 71);
    check("t6_csum", beats[70], 8'hFF);
    check("t6_csum_last", lasts[70], 1);
    check("t6_beat69_last", lasts[69], 0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
